// File: rtl/dp_mc_pkg.sv
// Shared types for the multicycle RV32I-subset core: FSM states, opcodes,
// ALU control codes, immediate formats and the control word the FSM emits.
package dp_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BEQ    = 4'd9,
        S_JAL    = 4'd10,
        S_HALT   = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctl_t;

    typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_t;
    typedef enum logic [1:0] {PC_SEQ, PC_ALUOUT, PC_ALU} pc_sel_t;
    typedef enum logic [1:0] {WB_ALUOUT, WB_MDR, WB_PC} wb_sel_t;

    typedef struct packed {
        logic     mem_req;
        logic     mem_we;
        logic     addr_data;   // 1: ALUOut drives the memory address, 0: PC
        logic     ir_we;
        logic     ab_we;
        logic     aluout_we;
        logic     mdr_we;
        logic     rf_we;
        logic     pc_we;
        logic     srca_pc;
        logic     srcb_imm;
        imm_t     imm_sel;
        alu_ctl_t alu_ctl;
        pc_sel_t  pc_sel;
        wb_sel_t  wb_sel;
    } ctrl_t;

    // Unsupported funct3 values fall back to add.
    function automatic alu_ctl_t alu_decode(input logic [2:0] funct3, input logic sub_bit);
        case (funct3)
            3'b000:  return sub_bit ? ALU_SUB : ALU_ADD;
            3'b111:  return ALU_AND;
            3'b110:  return ALU_OR;
            3'b010:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_fsm.sv
// Main control FSM of the multicycle core: sequences each instruction and
// produces every register enable, mux select and the memory request.
module mc_fsm
    import dp_mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       mem_ready,
    input  logic       a_eq_b,
    output state_t     state,
    output ctrl_t      ctrl
);

    state_t state_reg;
    state_t state_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= S_FETCH;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        ctrl       = '0;
        case (state_reg)
            S_FETCH: begin
                ctrl.mem_req = 1'b1;
                if (mem_ready) begin
                    ctrl.ir_we  = 1'b1;
                    ctrl.pc_we  = 1'b1;
                    ctrl.pc_sel = PC_SEQ;
                    state_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is computed speculatively while operands load.
                ctrl.ab_we     = 1'b1;
                ctrl.aluout_we = 1'b1;
                ctrl.srca_pc   = 1'b1;
                ctrl.srcb_imm  = 1'b1;
                ctrl.imm_sel   = IMM_B;
                ctrl.alu_ctl   = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECR;
                    OP_I:         state_next = S_EXECI;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_JAL:       state_next = S_JAL;
                    default:      state_next = S_HALT;
                endcase
            end
            S_MEMADR: begin
                ctrl.aluout_we = 1'b1;
                ctrl.srcb_imm  = 1'b1;
                ctrl.imm_sel   = (opcode == OP_SW) ? IMM_S : IMM_I;
                ctrl.alu_ctl   = ALU_ADD;
                state_next     = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                ctrl.mem_req   = 1'b1;
                ctrl.addr_data = 1'b1;
                if (mem_ready) begin
                    ctrl.mdr_we = 1'b1;
                    state_next  = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ctrl.rf_we  = 1'b1;
                ctrl.wb_sel = WB_MDR;
                state_next  = S_FETCH;
            end
            S_MEMWR: begin
                ctrl.mem_req   = 1'b1;
                ctrl.mem_we    = 1'b1;
                ctrl.addr_data = 1'b1;
                if (mem_ready) state_next = S_FETCH;
            end
            S_EXECR: begin
                ctrl.aluout_we = 1'b1;
                ctrl.alu_ctl   = alu_decode(funct3, funct7_5);
                state_next     = S_ALUWB;
            end
            S_EXECI: begin
                ctrl.aluout_we = 1'b1;
                ctrl.srcb_imm  = 1'b1;
                ctrl.imm_sel   = IMM_I;
                ctrl.alu_ctl   = alu_decode(funct3, 1'b0);
                state_next     = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.rf_we  = 1'b1;
                ctrl.wb_sel = WB_ALUOUT;
                state_next  = S_FETCH;
            end
            S_BEQ: begin
                ctrl.pc_we  = a_eq_b;
                ctrl.pc_sel = PC_ALUOUT;
                state_next  = S_FETCH;
            end
            S_JAL: begin
                ctrl.rf_we    = 1'b1;
                ctrl.wb_sel   = WB_PC;
                ctrl.pc_we    = 1'b1;
                ctrl.pc_sel   = PC_ALU;
                ctrl.srca_pc  = 1'b1;
                ctrl.srcb_imm = 1'b1;
                ctrl.imm_sel  = IMM_J;
                ctrl.alu_ctl  = ALU_ADD;
                state_next    = S_FETCH;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_HALT;
        endcase
    end

    assign state = state_reg;

endmodule

// File: rtl/dp_multicycle.sv
// Multicycle RV32I-subset core datapath: architectural registers, register
// file, ALU and immediate generation around a single shared memory port.
module dp_multicycle
    import dp_mc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              AW       = 16,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [AW-1:0]   pc,
    output logic            halt,
    output logic [3:0]      state
);

    logic [AW-1:0]   pc_reg, old_pc_reg, pc_next;
    logic [XLEN-1:0] ir_reg, mdr_reg, a_reg, b_reg, alu_out_reg;
    logic [XLEN-1:0] imm, srca, srcb, alu_result, wb_data;
    logic [XLEN-1:0] rf [32];
    logic [4:0]      rs1, rs2, rd;
    state_t          fsm_state;
    ctrl_t           ctrl;

    assign rs1 = ir_reg[19:15];
    assign rs2 = ir_reg[24:20];
    assign rd  = ir_reg[11:7];

    mc_fsm u_fsm (
        .clk       (clk),
        .rst       (rst),
        .opcode    (ir_reg[6:0]),
        .funct3    (ir_reg[14:12]),
        .funct7_5  (ir_reg[30]),
        .mem_ready (mem_ready),
        .a_eq_b    (a_reg == b_reg),
        .state     (fsm_state),
        .ctrl      (ctrl)
    );

    always_comb begin
        case (ctrl.imm_sel)
            IMM_S:   imm = {{(XLEN-12){ir_reg[31]}}, ir_reg[31:25], ir_reg[11:7]};
            IMM_B:   imm = {{(XLEN-13){ir_reg[31]}}, ir_reg[31], ir_reg[7],
                            ir_reg[30:25], ir_reg[11:8], 1'b0};
            IMM_J:   imm = {{(XLEN-21){ir_reg[31]}}, ir_reg[31], ir_reg[19:12],
                            ir_reg[20], ir_reg[30:21], 1'b0};
            default: imm = {{(XLEN-12){ir_reg[31]}}, ir_reg[31:20]};
        endcase
    end

    assign srca = ctrl.srca_pc  ? XLEN'(old_pc_reg) : a_reg;
    assign srcb = ctrl.srcb_imm ? imm : b_reg;

    always_comb begin
        case (ctrl.alu_ctl)
            ALU_SUB: alu_result = srca - srcb;
            ALU_AND: alu_result = srca & srcb;
            ALU_OR:  alu_result = srca | srcb;
            ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, ($signed(srca) < $signed(srcb))};
            default: alu_result = srca + srcb;
        endcase
    end

    always_comb begin
        case (ctrl.pc_sel)
            PC_ALUOUT: pc_next = alu_out_reg[AW-1:0];
            PC_ALU:    pc_next = alu_result[AW-1:0];
            default:   pc_next = pc_reg + AW'(4);
        endcase
    end

    // By JAL time PC already holds OldPC+4, which is the link value.
    always_comb begin
        case (ctrl.wb_sel)
            WB_MDR:  wb_data = mdr_reg;
            WB_PC:   wb_data = XLEN'(pc_reg);
            default: wb_data = alu_out_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg      <= RESET_PC;
            old_pc_reg  <= '0;
            ir_reg      <= '0;
            mdr_reg     <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            alu_out_reg <= '0;
        end else begin
            if (ctrl.ir_we) begin
                ir_reg     <= mem_rdata;
                old_pc_reg <= pc_reg;
            end
            if (ctrl.pc_we)     pc_reg      <= pc_next;
            if (ctrl.ab_we) begin
                a_reg <= rf[rs1];
                b_reg <= rf[rs2];
            end
            if (ctrl.aluout_we) alu_out_reg <= alu_result;
            if (ctrl.mdr_we)    mdr_reg     <= mem_rdata;
        end
    end

    // Entry 0 never takes a write, so x0 reads as zero without a read-side mux.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_rf
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    rf[gi] <= '0;
                else if (ctrl.rf_we && (gi != 0) && (rd == 5'(gi)))
                    rf[gi] <= wb_data;
            end
        end
    endgenerate

    // Gating with reset drops the request the instant reset asserts.
    assign mem_req   = ctrl.mem_req & rst;
    assign mem_we    = ctrl.mem_we;
    assign mem_addr  = ctrl.addr_data ? alu_out_reg[AW-1:0] : pc_reg;
    assign mem_wdata = b_reg;
    assign pc        = (fsm_state == S_FETCH) ? pc_reg : old_pc_reg;
    assign halt      = (fsm_state == S_HALT);
    assign state     = fsm_state;

endmodule

// File: tb/tb_dp_multicycle.sv
// Directed bench for dp_multicycle: a small program runs against a memory
// model; every bus transfer is matched against a queue of expected transfers.
module tb_dp_multicycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_we, mem_ready = 1'b1, halt;
    logic [15:0] mem_addr, pc;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  dbg_state;

    logic [31:0] mem [1024];

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          delta;
        int          stall;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0, errors = 0;
    int   cyc = 0, last_cyc = 0, wait_cnt = 0, n_tx = 0;
    int   next_base = 1, next_fstall = 0;
    logic        prev_wait = 1'b0, oldpc_pending = 1'b0;
    logic [49:0] held;
    logic [15:0] oldpc_exp;

    dp_multicycle #(.XLEN(32), .AW(16), .RESET_PC(16'h0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .pc        (pc),
        .halt      (halt),
        .state     (dbg_state)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[11:2]];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                          input logic [2:0] f3, input int rd);
        return {f7, rs2[4:0], rs1[4:0], f3, rd[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input logic [6:0] op, input int rd, input int rs1,
                                          input logic [2:0] f3, input int imm);
        return {imm[11:0], rs1[4:0], f3, rd[4:0], op};
    endfunction
    function automatic logic [31:0] enc_s(input int rs2, input int rs1, input int imm);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input int rs1, input int rs2, input int imm);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input int rd, input int imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction

    // Expected bus trace; delta is cycles since the previous transfer.
    task automatic push(input logic we, input logic [15:0] a, input logic [31:0] d,
                        input int base, input int st);
        exp_t e;
        e.we = we; e.addr = a; e.wdata = d; e.delta = base + st; e.stall = st;
        exp_q.push_back(e);
    endtask
    task automatic fetch(input logic [15:0] a, input int nb);
        push(1'b0, a, 32'h0, next_base, next_fstall);
        next_fstall = 0;
        next_base   = nb;
    endtask
    task automatic i_alu(input logic [15:0] a); fetch(a, 4); endtask
    task automatic i_br(input logic [15:0] a);  fetch(a, 3); endtask
    task automatic i_sw(input logic [15:0] a, input logic [15:0] da, input logic [31:0] d, input int st);
        fetch(a, 1);
        push(1'b1, da, d, 3, st);
    endtask
    task automatic i_lw(input logic [15:0] a, input logic [15:0] da, input int st);
        fetch(a, 2);
        push(1'b0, da, 32'h0, 3, st);
    endtask

    // Memory responder and bus monitor, evaluated away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            cyc = 0; last_cyc = 0; wait_cnt = 0;
            prev_wait = 1'b0; oldpc_pending = 1'b0;
            mem_ready = 1'b1;
        end else begin
            exp_t e;
            int   need;
            cyc++;
            if (oldpc_pending) begin
                check("pc_after_fetch", 64'(pc), 64'(oldpc_exp));
                oldpc_pending = 1'b0;
            end
            if (prev_wait)
                check("req_hold", 64'({mem_req, mem_we, mem_addr, mem_wdata}), 64'(held));
            need = (mem_req && exp_q.size() > 0) ? exp_q[0].stall : 0;
            mem_ready = (wait_cnt >= need);
            if (mem_req && mem_ready) begin
                n_tx++;
                $display("tx %0d cyc %0d %s addr=%h wdata=%h", n_tx, cyc,
                         mem_we ? "WR" : "RD", mem_addr, mem_we ? mem_wdata : 32'h0);
                if (exp_q.size() == 0) begin
                    check("unexpected_tx", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("bus_tx",
                          64'({mem_we, mem_addr, (mem_we ? mem_wdata : 32'h0), 8'(cyc - last_cyc)}),
                          64'({e.we, e.addr, (e.we ? e.wdata : 32'h0), 8'(e.delta)}));
                    if (!e.we && e.stall < 100 && e.addr < 16'h0100) begin
                        check("pc_in_fetch", 64'(pc), 64'(e.addr));
                        oldpc_pending = 1'b1;
                        oldpc_exp     = e.addr;
                    end
                end
                last_cyc  = cyc;
                wait_cnt  = 0;
                prev_wait = 1'b0;
            end else if (mem_req) begin
                wait_cnt++;
                prev_wait = 1'b1;
                held      = {mem_req, mem_we, mem_addr, mem_wdata};
            end else begin
                prev_wait = 1'b0;
            end
        end
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0000007F;
        mem[0]  = enc_i(7'h13, 1, 0, 3'b000, 5);          // addi x1,x0,5
        mem[1]  = enc_i(7'h13, 2, 0, 3'b000, 7);          // addi x2,x0,7
        mem[2]  = enc_r(7'h00, 2, 1, 3'b000, 3);          // add  x3,x1,x2
        mem[3]  = enc_s(3, 0, 'h100);                     // sw   x3,0x100(x0)
        mem[4]  = enc_b(1, 1, -8);                        // beq  x1,x1,-8
        mem[5]  = enc_i(7'h03, 4, 0, 3'b010, 'h104);      // lw   x4,0x104(x0)
        mem[6]  = enc_s(4, 0, 'h108);                     // sw   x4
        mem[7]  = enc_i(7'h13, 0, 0, 3'b000, 9);          // addi x0,x0,9
        mem[8]  = enc_j(5, 16);                           // jal  x5,+16
        mem[12] = enc_s(5, 0, 'h10C);                     // sw   x5
        mem[13] = enc_s(0, 0, 'h110);                     // sw   x0
        mem[14] = enc_r(7'h20, 2, 1, 3'b000, 6);          // sub  x6,x1,x2
        mem[15] = enc_r(7'h00, 1, 6, 3'b010, 7);          // slt  x7,x6,x1
        mem[16] = enc_r(7'h00, 2, 1, 3'b111, 8);          // and  x8,x1,x2
        mem[17] = enc_r(7'h00, 2, 1, 3'b110, 9);          // or   x9,x1,x2
        mem[18] = enc_i(7'h13, 10, 6, 3'b111, 'hF0);      // andi x10,x6,0xF0
        mem[19] = enc_i(7'h13, 11, 1, 3'b110, -16);       // ori  x11,x1,-16
        mem[20] = enc_i(7'h13, 12, 6, 3'b010, -1);        // slti x12,x6,-1
        for (int i = 0; i < 7; i++) mem[21 + i] = enc_s(6 + i, 0, 'h114 + 4 * i);
        mem[28] = enc_i(7'h03, 13, 0, 3'b010, 'h104);     // lw x13 (abandoned by reset)
        mem[65] = 32'hDEADBEEF;

        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_halt",    64'(halt),    64'd0);
        check("rst_pc",      64'(pc),      64'h0);
        check("rst_addr",    64'(mem_addr), 64'h0);

        next_base = 1;
        i_alu(16'h00); i_alu(16'h04); i_alu(16'h08);
        i_sw(16'h0C, 16'h100, 32'd12, 3);
        i_br(16'h10);
        next_fstall = 2;
        i_alu(16'h08);
        i_sw(16'h0C, 16'h100, 32'd12, 0);
        i_br(16'h10);
        i_lw(16'h14, 16'h104, 1);
        i_sw(16'h18, 16'h108, 32'hDEADBEEF, 0);
        i_alu(16'h1C);
        i_br(16'h20);
        i_sw(16'h30, 16'h10C, 32'h24, 0);
        i_sw(16'h34, 16'h110, 32'h0, 0);
        for (int i = 0; i < 7; i++) i_alu(16'(16'h38 + 4 * i));
        i_sw(16'h54, 16'h114, 32'hFFFFFFFE, 0);
        i_sw(16'h58, 16'h118, 32'd1, 0);
        i_sw(16'h5C, 16'h11C, 32'd5, 0);
        i_sw(16'h60, 16'h120, 32'd7, 0);
        i_sw(16'h64, 16'h124, 32'hF0, 0);
        i_sw(16'h68, 16'h128, 32'hFFFFFFF5, 0);
        i_sw(16'h6C, 16'h12C, 32'd1, 0);
        i_lw(16'h70, 16'h104, 1000);

        @(posedge clk); #1 rst = 1'b1;

        // Once the taken beq has been fetched, make the second pass fall through.
        for (int i = 0; i < 200 && n_tx < 6; i++) @(negedge clk);
        check("beq_first_fetch", 64'(n_tx >= 6), 64'd1);
        @(posedge clk); #1 mem[4] = enc_b(1, 2, -8);

        for (int i = 0; i < 3000 && exp_q.size() > 1; i++) @(negedge clk);
        check("reach_last_read", 64'(exp_q.size()), 64'd1);
        repeat (5) @(negedge clk);
        check("memrd_wait_req",  64'(mem_req),  64'd1);
        check("memrd_wait_addr", 64'(mem_addr), 64'h104);
        check("memrd_wait_we",   64'(mem_we),   64'd0);

        #2 rst = 1'b0;
        #1;
        check("async_rst_req",  64'(mem_req), 64'd0);
        check("async_rst_pc",   64'(pc),      64'h0);
        check("async_rst_halt", 64'(halt),    64'd0);
        exp_q.delete();
        mem[0] = 32'h0000007F;
        repeat (2) @(negedge clk);
        next_base   = 1;
        next_fstall = 0;
        i_br(16'h00);
        @(posedge clk); #1 rst = 1'b1;

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
        check("refetch_reset_pc", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            check("halt_flag", 64'(halt),    64'd1);
            check("halt_req",  64'(mem_req), 64'd0);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dp_multicycle.md
# dp_multicycle

Parametrised multicycle RV32I-subset core: datapath plus its main control FSM, executing one instruction over several clock cycles through a single shared instruction/data memory port with a valid/ready handshake. It supersedes the single-cycle datapath. Program and data share one memory, so the port carries only one transaction at a time. The block sits between the top level and the unified memory model.

## Interface
- XLEN, 32: datapath and register width.
- AW, 16: address width for PC and memory; PC is zero-extended to XLEN for arithmetic.
- RESET_PC, 0: PC value after reset.

- clk  in  1  system clock; everything rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = store, 0 = load/fetch; valid while mem_req=1.
- mem_addr  out  AW  word-aligned byte address.
- mem_wdata  out  XLEN  store data.
- mem_ready  in  1  memory accepts/completes the request this cycle.
- mem_rdata  in  XLEN  read data, valid in the mem_ready cycle of a read.
- pc  out  AW  architectural PC of the instruction in flight.
- halt  out  1  core stopped on an illegal/unsupported opcode.
- state  out  4  current FSM state code, for debug.

## Operation
- Supported opcodes:
  - lw, sw
  - R-type add/sub/and/or/slt
  - I-type addi/andi/ori/slti
  - beq, jal
- Any other opcode → HALT.
- Internal registers: PC, OldPC, IR, MDR, A, B, ALUOut. Register file is 32×XLEN; x0 reads 0 and writes to it are dropped.
- FSM states and transitions:
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. Stays in FETCH until mem_ready. On mem_ready: IR←mem_rdata, OldPC←PC, PC←PC+4, → DECODE.
  - DECODE: A←rs1 and B←rs2. ALUOut←OldPC+immB, the branch target. Then dispatch on opcode:
    - lw/sw → MEMADR
    - R → EXECR
    - I → EXECI
    - beq → BEQ
    - jal → JAL
    - otherwise → HALT
  - MEMADR: ALUOut←A+immI (lw) or A+immS (sw). → MEMRD for lw, MEMWR for sw.
  - MEMRD: mem_req=1, mem_addr=ALUOut[AW-1:0]. Stays until mem_ready, then MDR←mem_rdata, → MEMWB.
  - MEMWB: rd←MDR. → FETCH.
  - MEMWR: mem_req=1, mem_we=1, mem_wdata=B. Stays until mem_ready, then → FETCH.
  - EXECR / EXECI: ALUOut←A op B (R-type) or A op immI (I-type). → ALUWB.
  - ALUWB: rd←ALUOut. → FETCH.
  - BEQ: if A==B, PC←ALUOut. → FETCH.
  - JAL: rd←PC (already OldPC+4), PC←OldPC+immJ. → FETCH.
  - HALT: terminal; halt=1, mem_req=0. Only reset exits HALT.
- Arithmetic is mod 2^XLEN. PC updates are truncated to AW bits and wrap silently.
- Addresses are assumed word-aligned; bits [1:0] are passed through unchanged.

## Timing
- Reset values:
  - PC=RESET_PC; IR, MDR, A, B, ALUOut=0
  - all registers x0–x31 = 0
  - state=FETCH, mem_req=0 during reset, halt=0
- First cycle after reset release: mem_req=1 with mem_addr=RESET_PC.
- Handshake: a transfer completes on a cycle where mem_req=1 and mem_ready=1. While waiting, mem_req, mem_we, mem_addr and mem_wdata hold stable. mem_req never deasserts before the transfer completes, except on reset.
- Latency with mem_ready=1 on first request:

  | Instruction | Cycles |
  |---|---|
  | lw | 5 |
  | sw | 4 |
  | R/I-type | 4 |
  | jal | 3 |
  | beq | 3 |

  Each memory wait cycle adds 1.
- mem_ready while mem_req=0 is ignored.
- Async reset mid-transaction: mem_req drops immediately. The in-flight access is abandoned and no register-file write occurs.
- pc output equals OldPC from DECODE onward and equals PC during FETCH.

## Structure
- Package dp_mc_pkg holds:
  - state enum
  - opcode constants
  - 3-bit ALUControl encodings: add 000, sub 001, and 010, or 011, slt 101
  - immediate-type enum: I, S, B, J
- Sub-module mc_fsm: the control FSM, producing all register enables, mux selects and mem_req/mem_we.
- The datapath reuses the existing ALU, BR, SE and mux modules, widened to XLEN.

## Test plan
- Reset, then release with mem_ready=1. Program `addi x1,x0,5`; `addi x2,x0,7`; `add x3,x1,x2` → x3=12 after 12 cycles; pc sequence 0, 4, 8.
- `sw x3,0x40(x0)` with mem_ready held 0 for 3 cycles → mem_req/mem_addr=0x40/mem_wdata=12 stable for 4 cycles; one write occurs.
- Preload mem[0x40]=0xDEADBEEF; `lw x4,0x40(x0)` → x4=0xDEADBEEF, 5 cycles.
- `beq x1,x1,-8` at 0x10 → next fetch address 0x08. `beq x1,x2,-8` → next fetch address 0x14.
- `jal x5,+16` at 0x20 → x5=0x24, next fetch 0x30. `addi x0,x0,9` → x0 stays 0.
- Opcode 0x7F → halt=1, mem_req=0 indefinitely. Assert rst=0 mid-MEMRD wait → mem_req=0 at once, and after release the first fetch is at RESET_PC.
